// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and helpers for the instruction-memory loader.
package imem_loader_pkg;

  localparam int DEPTH = 100;  // instruction words in the store
  localparam int AW    = 8;    // address width, matches the PC
  localparam int DW    = 32;   // instruction word width

  // Frame start marker.
  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  // NOP opcode: the all-ones major opcode is reserved as no-operation.
  localparam logic [4:0]    NOP      = 5'h1F;
  localparam logic [DW-1:0] NOP_WORD = {NOP, 27'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  // A length byte is usable when it names between 1 and DEPTH words.
  function automatic logic len_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(DEPTH));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and fetch-read bundle between the loader and its environment.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  // Source of the byte stream and fetch address (host / pipeline side).
  modport master (
    output rx_valid, rx_data, rd_addr,
    input  rx_ready, rd_data
  );

  // The loader itself.
  modport slave (
    input  rx_valid, rx_data, rd_addr,
    output rx_ready, rd_data
  );

endinterface

// File: rtl/imem_loader_dp_ram.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Words are held XORed with NOP_WORD, so an all-zero array (the state a
// freshly configured block RAM powers up in) reads back as NOP everywhere
// without needing a reset or an init sequence.
module imem_dp_ram
  import imem_loader_pkg::*;
(
  input  logic          CLK,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int            IW      = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port; out-of-range addresses are dropped.
  always_ff @(posedge CLK) begin
    if (we_i && (waddr_i < DEPTH_A)) begin
      mem_q[waddr_i[IW-1:0]] <= wdata_i ^ NOP_WORD;
    end
  end

  // Asynchronous read; addresses past the store return NOP.
  assign rdata_o = (raddr_i < DEPTH_A) ? (mem_q[raddr_i[IW-1:0]] ^ NOP_WORD)
                                       : NOP_WORD;

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader: parses sync/length/payload/checksum frames,
// assembles big-endian words into the instruction store, holds the core in
// reset while loading.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset, waiting for start; core released
//   SYNC  | expecting the A5 sync byte
//   LEN   | expecting the word count (1..DEPTH)
//   DATA  | collecting payload bytes, writing a word every 4th byte
//   CSUM  | expecting the XOR of all payload bytes
//   DONE  | load succeeded; core released, waiting for a new start
//   ERR   | load aborted; core stays held until a new start
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          err,
  output logic [AW-1:0] word_count
);

  state_e        state_q;
  logic [7:0]    len_q;
  logic [1:0]    byte_idx_q;
  logic [23:0]   asm_q;
  logic [7:0]    xor_q;
  logic [AW-1:0] word_count_q;
  logic          cpu_hold_q;
  logic          load_done_q;
  logic          err_q;
  logic          rx_ready_q;

  logic          accept;
  logic          last_word;
  logic          wr_en_d;
  logic [DW-1:0] wr_word_d;

  assign accept    = bus.rx_valid && rx_ready_q;
  assign last_word = (word_count_q == (AW'(len_q) - 1'b1));

  // The word is written on the same edge that accepts its 4th byte.
  assign wr_en_d   = accept && (state_q == ST_DATA) && (byte_idx_q == 2'd3);
  assign wr_word_d = {asm_q, bus.rx_data};

  // Frame-parsing FSM with registered status outputs.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      xor_q        <= '0;
      word_count_q <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      err_q        <= 1'b0;
      rx_ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q      <= ST_SYNC;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            xor_q        <= '0;
            word_count_q <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
            rx_ready_q   <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (accept) begin
            if (bus.rx_data == LOADER_SYNC) begin
              state_q <= ST_LEN;
            end else begin
              state_q    <= ST_ERR;
              err_q      <= 1'b1;
              rx_ready_q <= 1'b0;
            end
          end
        end
        ST_LEN: begin
          if (accept) begin
            if (len_ok(bus.rx_data)) begin
              len_q   <= bus.rx_data;
              state_q <= ST_DATA;
            end else begin
              state_q    <= ST_ERR;
              err_q      <= 1'b1;
              rx_ready_q <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            asm_q      <= {asm_q[15:0], bus.rx_data};
            xor_q      <= xor_q ^ bus.rx_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              word_count_q <= word_count_q + 1'b1;
              if (last_word) begin
                state_q <= ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (bus.rx_data == xor_q) begin
              state_q     <= ST_DONE;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  imem_dp_ram u_ram (
    .CLK     (CLK),
    .we_i    (wr_en_d),
    .waddr_i (word_count_q),
    .wdata_i (wr_word_d),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.rx_ready = rx_ready_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign err          = err_q;
  assign word_count   = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-position reference model,
// per-cycle compare process, and literal checks that pin the model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  localparam logic [31:0] NOP_LIT = 32'hF800_0000;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_hold;
  logic       load_done;
  logic       err;
  logic [7:0] word_count;

  imem_loader_if bus();

  imem_loader dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: what the outputs must be, by position within the frame.
  bit          m_loading, m_hold, m_done, m_err, m_acc;
  int          m_pos, m_n, m_wc;
  logic [7:0]  m_xor;
  logic [31:0] m_word;
  logic [31:0] m_mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    return (a < 8'd100) ? m_mem[a] : NOP_LIT;
  endfunction

  // Advance the model by one clock edge using the inputs the bench drove.
  task automatic model_step();
    logic [7:0] b;
    b = bus.rx_data;
    m_acc = 1'b0;
    if (!reset) begin
      m_loading = 0; m_hold = 0; m_done = 0; m_err = 0; m_wc = 0;
    end else if (!m_loading) begin
      if (start) begin
        m_loading = 1; m_pos = 0; m_wc = 0; m_xor = 0;
        m_err = 0; m_done = 0; m_hold = 1;
      end
    end else if (bus.rx_valid) begin
      m_acc = 1'b1;
      if (m_pos == 0) begin
        if (b != 8'hA5) begin m_loading = 0; m_err = 1; end
      end else if (m_pos == 1) begin
        if (b == 8'd0 || b > 8'd100) begin m_loading = 0; m_err = 1; end
        else m_n = int'(b);
      end else if (m_pos < 4 * m_n + 2) begin
        m_xor  = m_xor ^ b;
        m_word = {m_word[23:0], b};
        if ((m_pos - 2) % 4 == 3) begin
          m_mem[m_wc] = m_word;
          m_wc++;
        end
      end else begin
        if (b == m_xor) begin m_loading = 0; m_done = 1; m_hold = 0; end
        else begin m_loading = 0; m_err = 1; end
      end
      m_pos++;
    end
  endtask

  // Every cycle, compare the DUT against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("rx_ready",   32'(bus.rx_ready), 32'(m_loading));
      check("cpu_hold",   32'(cpu_hold),     32'(m_hold));
      check("load_done",  32'(load_done),    32'(m_done));
      check("err",        32'(err),          32'(m_err));
      check("word_count", 32'(word_count),   32'(m_wc));
      check("rd_data",    bus.rd_data,       m_read(bus.rd_addr));
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    bus.rd_addr = 8'($urandom_range(0, 110));
  endtask

  task automatic peek(input string name, input logic [7:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    #1;
    check(name, bus.rd_data, exp);
  endtask

  function automatic bq_t build(input logic [7:0] n, input wq_t w, input bit bad);
    bq_t fr;
    logic [7:0] x;
    logic [31:0] wd;
    x  = 8'h00;
    fr = '{8'hA5, n};
    foreach (w[i]) begin
      wd = w[i];
      for (int k = 3; k >= 0; k--) begin
        fr.push_back(wd[8*k +: 8]);
        x = x ^ wd[8*k +: 8];
      end
    end
    fr.push_back(bad ? 8'h00 : x);
    return fr;
  endfunction

  // Pulse start, then stream bytes until the frame ends, the loader stops
  // accepting, max_acc bytes went in, or the cycle budget runs out.
  task automatic send(input bq_t fr, input int gap_pct, input int max_acc,
                      output int acc, output int cyc);
    acc = 0;
    cyc = 0;
    start = 1'b1;
    bus.rx_valid = 1'b0;
    tick();
    start = 1'b0;
    while (m_loading && acc < fr.size() && acc < max_acc && cyc < 6000) begin
      bus.rx_valid = ($urandom_range(0, 99) >= gap_pct);
      bus.rx_data  = bus.rx_valid ? fr[acc] : 8'($urandom);
      start        = ($urandom_range(0, 9) == 0);
      tick();
      cyc++;
      if (m_acc) acc++;
    end
    bus.rx_valid = 1'b0;
    start = 1'b0;
    check("send_budget", 32'(cyc >= 6000), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t fr;
    wq_t w100;
    int acc, cyc;

    reset = 1'b0; start = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rd_addr = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = NOP_LIT;
    m_loading = 0; m_hold = 0; m_done = 0; m_err = 0; m_acc = 0;
    m_pos = 0; m_n = 0; m_wc = 0; m_xor = 0; m_word = 0;

    tick(); tick();
    reset = 1'b1;
    chk_en = 1'b1;

    // Reset state.
    check("rst_rx_ready",  32'(bus.rx_ready), 32'd0);
    check("rst_cpu_hold",  32'(cpu_hold),     32'd0);
    check("rst_wc",        32'(word_count),   32'd0);
    peek("rst_nop_word", 8'd5, NOP_LIT);

    // Two-word frame, one byte per cycle. Payload XOR is 8'h88.
    fr = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send(fr, 0, 1000, acc, cyc);
    check("t1_cycles",    32'(cyc),        32'd11);
    check("t1_done",      32'(load_done),  32'd1);
    check("t1_wc",        32'(word_count), 32'd2);
    check("t1_hold",      32'(cpu_hold),   32'd0);
    peek("t1_addr0", 8'd0, 32'h1122_3344);
    peek("t1_addr1", 8'd1, 32'h5566_7788);

    // Bad checksum: abort, but the words stay written.
    fr = build(8'd2, '{32'hDEAD_BEEF, 32'h0102_0304}, 1'b1);
    send(fr, 0, 1000, acc, cyc);
    check("t2_err",  32'(err),      32'd1);
    check("t2_hold", 32'(cpu_hold), 32'd1);
    check("t2_done", 32'(load_done), 32'd0);
    peek("t2_addr0", 8'd0, 32'hDEAD_BEEF);
    peek("t2_addr1", 8'd1, 32'h0102_0304);

    // Bad sync byte.
    fr = '{8'h5A, 8'h02, 8'h11, 8'h22};
    send(fr, 0, 1000, acc, cyc);
    check("t3_acc",   32'(acc),          32'd1);
    check("t3_err",   32'(err),          32'd1);
    check("t3_ready", 32'(bus.rx_ready), 32'd0);
    check("t3_wc",    32'(word_count),   32'd0);
    peek("t3_addr0", 8'd0, 32'hDEAD_BEEF);

    // Length out of range at both ends, then a good one-word frame.
    fr = '{8'hA5, 8'h00, 8'h11};
    send(fr, 0, 1000, acc, cyc);
    check("t4_len0_acc", 32'(acc), 32'd2);
    check("t4_len0_err", 32'(err), 32'd1);
    fr = '{8'hA5, 8'd101, 8'h11};
    send(fr, 0, 1000, acc, cyc);
    check("t4_len101_acc", 32'(acc), 32'd2);
    check("t4_len101_err", 32'(err), 32'd1);
    check("t4_len101_wc",  32'(word_count), 32'd0);
    fr = build(8'd1, '{32'hCAFE_F00D}, 1'b0);
    send(fr, 0, 1000, acc, cyc);
    check("t4_done", 32'(load_done),  32'd1);
    check("t4_wc",   32'(word_count), 32'd1);
    peek("t4_addr0", 8'd0, 32'hCAFE_F00D);

    // Full 100-word frame with random valid gaps.
    for (int i = 0; i < 100; i++) w100.push_back($urandom);
    fr = build(8'd100, w100, 1'b0);
    send(fr, 30, 1000, acc, cyc);
    check("t5_done", 32'(load_done),  32'd1);
    check("t5_wc",   32'(word_count), 32'd100);
    for (int i = 0; i < 100; i++) begin
      tick();
      peek("t5_word", 8'(i), w100[i]);
    end
    peek("t5_addr100", 8'd100, NOP_LIT);
    peek("t5_addr255", 8'd255, NOP_LIT);

    // Reset after six payload bytes: first word landed, second untouched.
    fr = build(8'd2, '{32'hA1B2_C3D4, 32'h0F0E_0D0C}, 1'b0);
    send(fr, 0, 8, acc, cyc);
    check("t6_acc", 32'(acc), 32'd8);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_hold",  32'(cpu_hold),     32'd0);
    check("t6_ready", 32'(bus.rx_ready), 32'd0);
    check("t6_wc",    32'(word_count),   32'd0);
    peek("t6_addr0", 8'd0, 32'hA1B2_C3D4);
    peek("t6_addr1", 8'd1, w100[1]);

    // Recovery after reset with a gapped one-word frame.
    fr = build(8'd1, '{32'h1234_5678}, 1'b0);
    send(fr, 50, 1000, acc, cyc);
    check("t7_done", 32'(load_done), 32'd1);
    peek("t7_addr0", 8'd0, 32'h1234_5678);

    tick(); tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
